// File: rtl/pipe_buf_pr_if.sv
// Handshake bundle for pipe_buf_pr and the shared pipeline retain/clear control.
// Masters drive a buffer; slaves are the buffer itself.
interface pipeline_ctrl_ifc;
  logic retain;
  logic clear;

  modport in  (input  retain, input  clear);
  modport out (output retain, output clear);
endinterface

interface pipe_buf_pr_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic [CNT_W-1:0]  count;

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, count
  );

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, count
  );
endinterface

// File: rtl/pipe_buf_pr.sv
// Elastic DEPTH-entry pipeline register with valid/ready handshake and retain/clear control.
// Optional high-water-mark output enabled by defining PIPE_BUF_PR_HWM_EN.
module pipe_buf_pr #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       n_rst,
  pipeline_ctrl_ifc.in               ctrl,
  pipe_buf_pr_if.slave               bus
`ifdef PIPE_BUF_PR_HWM_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] hwm
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              push;
  logic              pop;

  // Explicit wrap so non-power-of-two depths never walk past the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign bus.o_ready = (count_q != CNT_FULL) & ~ctrl.retain;
  assign bus.o_valid = (count_q != '0);
  assign bus.o_data  = mem_q[rd_ptr_q];
  assign bus.count   = count_q;

  assign push = bus.i_valid & bus.o_ready;
  assign pop  = bus.o_valid & bus.i_ready & ~ctrl.retain;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (ctrl.clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!n_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Clear only rewinds the pointers; payload storage is left untouched.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      // NOTE: storage is reset on purpose so o_data reads 0 after reset, not stale payload.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !ctrl.clear) begin
      mem_q[wr_ptr_q] <= bus.i_data;
    end
  end

`ifdef PIPE_BUF_PR_HWM_EN
  logic [CNT_W-1:0] hwm_q;

  // Tracks registered occupancy, so it trails count by one cycle and ignores clear.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      hwm_q <= '0;
    end else if (count_q > hwm_q) begin
      hwm_q <= count_q;
    end
  end

  assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_pipe_buf_pr.sv
// Bench for pipe_buf_pr: DEPTH=2 and DEPTH=3 instances share stimulus and are
// compared every cycle against a queue model, plus hand-computed directed checks.
module tb_pipe_buf_pr;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          n_rst;
  logic          i_valid;
  logic          i_ready;
  logic          retain;
  logic          clear;
  logic [DW-1:0] i_data;

  pipeline_ctrl_ifc ctl ();
  pipe_buf_pr_if #(.DATA_W(DW), .DEPTH(2)) b2 ();
  pipe_buf_pr_if #(.DATA_W(DW), .DEPTH(3)) b3 ();

  assign ctl.retain = retain;
  assign ctl.clear  = clear;
  assign b2.i_valid = i_valid;
  assign b2.i_data  = i_data;
  assign b2.i_ready = i_ready;
  assign b3.i_valid = i_valid;
  assign b3.i_data  = i_data;
  assign b3.i_ready = i_ready;

`ifdef PIPE_BUF_PR_HWM_EN
  logic [1:0] hwm2;
  logic [1:0] hwm3;
`endif

  pipe_buf_pr #(.DATA_W(DW), .DEPTH(2)) u2 (
    .clk   (clk),
    .n_rst (n_rst),
    .ctrl  (ctl),
    .bus   (b2)
`ifdef PIPE_BUF_PR_HWM_EN
    ,
    .hwm   (hwm2)
`endif
  );

  pipe_buf_pr #(.DATA_W(DW), .DEPTH(3)) u3 (
    .clk   (clk),
    .n_rst (n_rst),
    .ctrl  (ctl),
    .bus   (b3)
`ifdef PIPE_BUF_PR_HWM_EN
    ,
    .hwm   (hwm3)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each buffer is just a bounded FIFO queue.
  logic [DW-1:0] q2 [$];
  logic [DW-1:0] q3 [$];
  int            hwm2_m = 0;
  int            hwm3_m = 0;
  bit            started = 1'b0;
  bit            m_pop;
  bit            m_push;

  function automatic void decide(input int sz, input int d, output bit do_pop, output bit do_push);
    do_pop  = (sz != 0) && i_ready && !retain;
    do_push = i_valid && (sz != d) && !retain;
  endfunction

  always @(posedge clk) begin
    if (!n_rst) begin
      q2.delete();
      q3.delete();
      hwm2_m  = 0;
      hwm3_m  = 0;
      started = 1'b1;
    end else begin
      if (q2.size() > hwm2_m) hwm2_m = q2.size();
      if (q3.size() > hwm3_m) hwm3_m = q3.size();
      if (clear) begin
        q2.delete();
        q3.delete();
      end else begin
        decide(q2.size(), 2, m_pop, m_push);
        if (m_pop)  void'(q2.pop_front());
        if (m_push) q2.push_back(i_data);
        decide(q3.size(), 3, m_pop, m_push);
        if (m_pop)  void'(q3.pop_front());
        if (m_push) q3.push_back(i_data);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("m2.o_valid", 32'(b2.o_valid), 32'(q2.size() != 0));
      check("m2.o_ready", 32'(b2.o_ready), 32'((q2.size() != 2) && !retain));
      check("m2.count",   32'(b2.count),   32'(q2.size()));
      if (q2.size() != 0) check("m2.o_data", 32'(b2.o_data), 32'(q2[0]));
      check("m3.o_valid", 32'(b3.o_valid), 32'(q3.size() != 0));
      check("m3.o_ready", 32'(b3.o_ready), 32'((q3.size() != 3) && !retain));
      check("m3.count",   32'(b3.count),   32'(q3.size()));
      if (q3.size() != 0) check("m3.o_data", 32'(b3.o_data), 32'(q3[0]));
`ifdef PIPE_BUF_PR_HWM_EN
      check("m2.hwm", 32'(hwm2), 32'(hwm2_m));
      check("m3.hwm", 32'(hwm3), 32'(hwm3_m));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [DW-1:0] stream_v [3] = '{8'h11, 8'h22, 8'h33};

  initial begin
    n_rst   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    retain  = 1'b0;
    clear   = 1'b0;
    i_data  = '0;
    tick();
    tick();
    n_rst = 1'b1;
    #1;

    check("rst.o_valid", 32'(b2.o_valid), 0);
    check("rst.o_data",  32'(b2.o_data),  0);
    check("rst.count",   32'(b2.count),   0);
    check("rst.o_ready", 32'(b2.o_ready), 1);
    check("rst.o_data3", 32'(b3.o_data),  0);

    // Streaming with downstream always ready: one cycle latency, occupancy stays 1.
    i_ready = 1'b1;
    i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_data = stream_v[i];
      tick();
      check("stream.o_data",  32'(b2.o_data),  32'(stream_v[i]));
      check("stream.o_valid", 32'(b2.o_valid), 1);
      check("stream.count",   32'(b2.count),   1);
    end
    i_valid = 1'b0;
    tick();
    check("stream.drained", 32'(b2.count), 0);

    // Backpressure until full; the fourth beat must be refused by DEPTH=3.
    i_ready = 1'b0;
    i_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_data = 8'(8'hA0 + i);
      if (i == 3) begin
        #1;
        check("full.o_ready", 32'(b3.o_ready), 0);
      end
      tick();
    end
    check("full.count3", 32'(b3.count),  3);
    check("full.head3",  32'(b3.o_data), 32'hA0);
    check("full.count2", 32'(b2.count),  2);
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("drain.o_data", 32'(b3.o_data), 32'hA0 + 32'(i));
      tick();
    end
    check("drain.count", 32'(b3.count), 0);

    // Pointer wrap 2 -> 0 on DEPTH=3 while pushing and popping together.
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 8'hB0;
    tick();
    i_data  = 8'hB1;
    tick();
    i_ready = 1'b1;
    i_data  = 8'hB2;
    tick();
    i_data  = 8'hB3;
    tick();
    check("wrap.head",  32'(b3.o_data), 32'hB2);
    check("wrap.count", 32'(b3.count),  2);
    i_valid = 1'b0;
    tick();
    check("wrap.next", 32'(b3.o_data), 32'hB3);
    tick();
    tick();

    // Retain with count=2, head 0x55: nothing moves for three cycles.
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 8'h55;
    tick();
    i_data  = 8'h66;
    tick();
    retain  = 1'b1;
    i_ready = 1'b1;
    i_data  = 8'h77;
    #1;
    check("retain.o_ready2", 32'(b2.o_ready), 0);
    check("retain.o_ready3", 32'(b3.o_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("retain.count",  32'(b3.count),  2);
      check("retain.o_data", 32'(b3.o_data), 32'h55);
      check("retain.count2", 32'(b2.count),  2);
    end

    // Clear beats retain and discards the beat offered alongside it.
    clear  = 1'b1;
    i_data = 8'h99;
    tick();
    clear   = 1'b0;
    retain  = 1'b0;
    i_valid = 1'b0;
    #1;
    check("clear.count",   32'(b2.count),   0);
    check("clear.o_valid", 32'(b2.o_valid), 0);
    check("clear.count3",  32'(b3.count),   0);
`ifdef PIPE_BUF_PR_HWM_EN
    check("clear.hwm", 32'(hwm2), 2);
`endif
    tick();
    tick();
    check("clear.idle", 32'(b3.o_valid), 0);
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 8'h42;
    tick();
    i_valid = 1'b0;
    check("clear.refill", 32'(b3.o_data), 32'h42);
    check("clear.count1", 32'(b3.count),  1);

    // Reset in the middle of operation also wipes storage.
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    #1;
    check("mrst.o_data",  32'(b3.o_data),  0);
    check("mrst.count",   32'(b3.count),   0);
    check("mrst.o_valid", 32'(b2.o_valid), 0);
`ifdef PIPE_BUF_PR_HWM_EN
    check("mrst.hwm", 32'(hwm3), 0);
`endif
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
